program_loader: RTL and testbench

- Write-side counterpart to the instruction memory read port; it fills instruction memory from a byte stream.
- Accepts bytes over a valid/ready handshake, packs them MSB-first into size-bit instruction words, and issues one write pulse per word at consecutive word addresses starting at 0.
- Holds the CPU in reset (cpuHold) while loading; pulses done when finished.

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 154 +++++++++++++++
 tb/tb_program_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for program_loader.
// slave is the loader's view; master is the byte source / memory side.
interface program_loader_if #(
  parameter int size   = 32,
  parameter int length = 256
);
  logic [7:0]                byteIn;
  logic                      byteValid;
  logic                      byteReady;
  logic                      memWriteEnable;
  logic [$clog2(length)-1:0] memWriteAddress;
  logic [size-1:0]           memWriteData;

  modport master (
    output byteIn, byteValid,
    input  byteReady, memWriteEnable, memWriteAddress, memWriteData
  );

  modport slave (
    input  byteIn, byteValid,
    output byteReady, memWriteEnable, memWriteAddress, memWriteData
  );
endinterface

// File: rtl/program_loader.sv
// Fills instruction memory from a byte stream, packing MSB-first into size-bit words.
// Optional trailing checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int size   = 32,
  parameter int length = 256
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic [$clog2(length):0] wordCount,
  program_loader_if.slave         bus,
  output logic                    busy,
  output logic                    cpuHold,
  output logic                    done,
  output logic                    checksumError
);
  localparam int AW  = $clog2(length);
  localparam int CW  = AW + 1;
  localparam int BPW = size / 8;
  localparam int BW  = $clog2(BPW) + 1;
  localparam logic [CW-1:0] LEN = CW'(length);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  state_t          state, next_state;
  logic [BW-1:0]   byte_cnt;
  logic [CW-1:0]   word_cnt;
  logic [CW-1:0]   target;
  logic [size-1:0] shift;
  logic [size-1:0] assembled;
  logic [size-1:0] mem_data;
  logic [AW-1:0]   mem_addr;
  logic            ready;
  logic            write_en;
  logic            xfer;
  logic            last_byte;
  logic            last_word;

  assign xfer      = bus.byteValid & bus.byteReady;
  assign last_byte = (byte_cnt == BW'(BPW - 1));
  assign last_word = ((word_cnt + CW'(1)) == target);
  assign assembled = (shift << 8) | size'(bus.byteIn);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    write_en   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (wordCount == '0) ? DONE : LOAD;
      end
      LOAD: begin
        ready = 1'b1;
        if (bus.byteValid && last_byte) next_state = WRITE;
      end
      WRITE: begin
        write_en = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        next_state = last_word ? CHECK : LOAD;
`else
        next_state = last_word ? DONE : LOAD;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        ready = 1'b1;
        if (bus.byteValid) next_state = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Address/data are captured with the final byte so they stay stable outside WRITE.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      target   <= '0;
      shift    <= '0;
      mem_data <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target   <= (wordCount > LEN) ? LEN : wordCount;
            word_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            shift    <= assembled;
            byte_cnt <= byte_cnt + BW'(1);
            if (last_byte) begin
              mem_data <= assembled;
              mem_addr <= word_cnt[AW-1:0];
            end
          end
        end
        WRITE: begin
          byte_cnt <= '0;
          word_cnt <= word_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_err;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else if (state == IDLE && start) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else if (state == LOAD && xfer) begin
      sum <= sum + bus.byteIn;
    end else if (state == CHECK && xfer) begin
      chk_err <= ((sum + bus.byteIn) != 8'd0);
    end
  end

  assign checksumError = chk_err;
`else
  assign checksumError = 1'b0;
`endif

  assign bus.byteReady       = ready;
  assign bus.memWriteEnable  = write_en;
  assign bus.memWriteAddress = mem_addr;
  assign bus.memWriteData    = mem_data;
  assign busy                = (state != IDLE);
  assign cpuHold             = busy;
endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (size=32, length=256).
module tb_program_loader;
  localparam int SIZE   = 32;
  localparam int LENGTH = 256;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic [8:0] wordCount = '0;
  logic       busy, cpuHold, done, checksumError;

  program_loader_if #(.size(SIZE), .length(LENGTH)) bus();

  program_loader #(.size(SIZE), .length(LENGTH)) dut (
    .clk(clk), .resetN(resetN), .start(start), .wordCount(wordCount),
    .bus(bus), .busy(busy), .cpuHold(cpuHold), .done(done),
    .checksumError(checksumError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // write/done monitor, sampled on the falling edge
  logic [7:0]  wr_addr [0:511];
  logic [31:0] wr_data [0:511];
  int n = 0, done_cnt = 0, we_dup = 0, done_dup = 0, hold_low = 0;
  logic prev_we = 1'b0, prev_done = 1'b0;
  logic [7:0] sent_sum = '0;

  always @(negedge clk) begin
    if (resetN) begin
      if (bus.memWriteEnable) begin
        if (n < 512) begin
          wr_addr[n] = bus.memWriteAddress;
          wr_data[n] = bus.memWriteData;
        end
        n++;
        if (prev_we) we_dup++;
      end
      if (done) begin
        done_cnt++;
        if (prev_done) done_dup++;
      end
      prev_we   = bus.memWriteEnable;
      prev_done = done;
    end else begin
      prev_we   = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n = 0; done_cnt = 0; we_dup = 0; done_dup = 0; hold_low = 0;
  endtask

  // called at a falling edge; returns at the falling edge after the transfer
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    if (gap) begin
      bus.byteValid = 1'b0;
      @(negedge clk);
    end
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    guard = 0;
    while (!bus.byteReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("byte_ready_timeout", 32'(guard), 32'd0);
    if (!cpuHold) hold_low++;
    sent_sum = sent_sum + b;
    @(negedge clk);
    bus.byteValid = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] wc);
    start     = 1'b1;
    wordCount = wc;
    @(negedge clk);
    start     = 1'b0;
    wordCount = '0;
    sent_sum  = '0;
  endtask

  task automatic finish_load(input bit gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'd0 - sent_sum;
    send_byte(c, gap);
`else
    if (gap) @(negedge clk);
`endif
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [7:0] prog [0:7];
  logic [7:0] b;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
    prog[4] = 8'h00; prog[5] = 8'h22; prog[6] = 8'h18; prog[7] = 8'h20;
    bus.byteIn    = '0;
    bus.byteValid = 1'b0;

    // reset values
    #3;
    check("rst_byteReady", 32'(bus.byteReady), 32'd0);
    check("rst_we", 32'(bus.memWriteEnable), 32'd0);
    check("rst_addr", 32'(bus.memWriteAddress), 32'd0);
    check("rst_data", bus.memWriteData, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpuHold", 32'(cpuHold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_chkerr", 32'(checksumError), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    bus.byteValid = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_byteReady", 32'(bus.byteReady), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    bus.byteValid = 1'b0;

    // two-word load, byteValid held high
    clear_mon();
    do_start(9'd2);
    check("load_busy", 32'(busy), 32'd1);
    check("load_cpuHold", 32'(cpuHold), 32'd1);
    check("load_byteReady", 32'(bus.byteReady), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], 1'b0);
      if (i == 3) check("w0_strobe", 32'(bus.memWriteEnable), 32'd1);
    end
    check("w1_strobe", 32'(bus.memWriteEnable), 32'd1);
    finish_load(1'b0);
    wait_done("two_done");
    check("two_cpuHold_at_done", 32'(cpuHold), 32'd1);
    settle();
    check("two_cpuHold_after", 32'(cpuHold), 32'd0);
    check("two_done_after", 32'(done), 32'd0);
    check("two_nwrites", 32'(n), 32'd2);
    check("two_addr0", 32'(wr_addr[0]), 32'd0);
    check("two_data0", wr_data[0], 32'h8C010004);
    check("two_addr1", 32'(wr_addr[1]), 32'd1);
    check("two_data1", wr_data[1], 32'h00221820);
    check("two_we_width", 32'(we_dup), 32'd0);
    check("two_done_cnt", 32'(done_cnt), 32'd1);
    check("two_done_width", 32'(done_dup), 32'd0);
    check("two_hold", 32'(hold_low), 32'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    check("two_chkerr_tied", 32'(checksumError), 32'd0);
`endif

    // stalls with start pulses mid-load
    clear_mon();
    do_start(9'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], 1'b1);
      if (i == 2 || i == 5) begin
        start = 1'b1; wordCount = 9'd7;
        @(negedge clk);
        start = 1'b0; wordCount = '0;
      end
    end
    finish_load(1'b1);
    wait_done("stall_done");
    settle();
    check("stall_nwrites", 32'(n), 32'd2);
    check("stall_addr0", 32'(wr_addr[0]), 32'd0);
    check("stall_data0", wr_data[0], 32'h8C010004);
    check("stall_addr1", 32'(wr_addr[1]), 32'd1);
    check("stall_data1", wr_data[1], 32'h00221820);
    check("stall_done_cnt", 32'(done_cnt), 32'd1);
    check("stall_hold", 32'(hold_low), 32'd0);
    check("stall_busy_after", 32'(busy), 32'd0);

    // zero word count
    clear_mon();
    do_start(9'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_chkerr", 32'(checksumError), 32'd0);
    settle();
    check("zero_done_after", 32'(done), 32'd0);
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_nwrites", 32'(n), 32'd0);

    // clamp: 300 requested, 256 loaded
    clear_mon();
    do_start(9'd300);
    for (int w = 0; w < 256; w++) begin
      b = 8'(w);
      send_byte(b, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(~b, 1'b0);
      send_byte(8'h3C, 1'b0);
    end
    finish_load(1'b0);
    wait_done("clamp_done");
    repeat (3) settle();
    check("clamp_nwrites", 32'(n), 32'd256);
    check("clamp_first_data", wr_data[0], 32'h00A5FF3C);
    check("clamp_last_addr", 32'(wr_addr[255]), 32'd255);
    check("clamp_last_data", wr_data[255], 32'hFFA5003C);
    check("clamp_mid_addr", 32'(wr_addr[128]), 32'd128);
    check("clamp_mid_data", wr_data[128], 32'h80A57F3C);
    check("clamp_busy_after", 32'(busy), 32'd0);

    // reset mid-load
    clear_mon();
    do_start(9'd4);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
    resetN = 1'b0;
    #1;
    check("abort_byteReady", 32'(bus.byteReady), 32'd0);
    check("abort_we", 32'(bus.memWriteEnable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cpuHold", 32'(cpuHold), 32'd0);
    check("abort_data", bus.memWriteData, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    clear_mon();
    do_start(9'd1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    finish_load(1'b0);
    wait_done("reload_done");
    settle();
    check("reload_nwrites", 32'(n), 32'd1);
    check("reload_addr0", 32'(wr_addr[0]), 32'd0);
    check("reload_data0", wr_data[0], 32'h12345678);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // good checksum: 01+02+03+04+F6 = 0x100
    do_start(9'd1);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF6, 1'b0);
    wait_done("chk_good_done");
    check("chk_good_err", 32'(checksumError), 32'd0);
    settle();
    // bad checksum
    do_start(9'd1);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF5, 1'b0);
    wait_done("chk_bad_done");
    check("chk_bad_err", 32'(checksumError), 32'd1);
    repeat (4) @(negedge clk);
    check("chk_bad_held", 32'(checksumError), 32'd1);
    do_start(9'd1);
    check("chk_cleared_on_start", 32'(checksumError), 32'd0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hF6, 1'b0);
    wait_done("chk_final_done");
    settle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
